// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl_if
//  Description : Value/strobe and LED-pin bundle of the 7-segment scan
//                controller. The master side supplies display values, and
//                the slave side (the scan controller) drives the LED pins.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seg7_scan_ctrl_if #(
  parameter int NDIG = 4
);
  logic              load;
  logic [4*NDIG-1:0] data;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   den;
  logic              busy;
  logic              frame_tick;
  logic [NDIG-1:0]   an;
  logic [7:0]        seg;

  modport master (
    output load, data, dp, den,
    input  busy, frame_tick, an, seg
  );

  modport slave (
    input  load, data, dp, den,
    output busy, frame_tick, an, seg
  );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_ctrl
//  Description : Time-multiplexed scan controller for an NDIG-digit
//                common-bus 7-segment display. It holds a double-buffered hex
//                value that is applied only at frame boundaries. There are
//                blank guard clocks at the start of every slot, and leading
//                zeros can optionally be suppressed.
//  Revision    : 1.0 - initial release
// ============================================================================

// Hex nibble to {a,b,c,d,e,f,g,0} segment pattern, active-high.
module decode_7seg (
  input  logic [3:0] nibble,
  output logic [7:0] pattern
);
  // Pure lookup; bit 0 is left clear for the decimal point.
  always_comb begin
    pattern = 8'h00;
    case (nibble)
      4'h0: pattern = 8'hFC;
      4'h1: pattern = 8'h60;
      4'h2: pattern = 8'hDA;
      4'h3: pattern = 8'hF2;
      4'h4: pattern = 8'h66;
      4'h5: pattern = 8'hB6;
      4'h6: pattern = 8'hBE;
      4'h7: pattern = 8'hE0;
      4'h8: pattern = 8'hFE;
      4'h9: pattern = 8'hF6;
      4'hA: pattern = 8'hEE;
      4'hB: pattern = 8'h3E;
      4'hC: pattern = 8'h9C;
      4'hD: pattern = 8'h7A;
      4'hE: pattern = 8'h9E;
      4'hF: pattern = 8'h8E;
      default: pattern = 8'h00;
    endcase
  end
endmodule

module seg7_scan_ctrl #(
  parameter int NDIG  = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 16,
  parameter int LZS   = 0
) (
  input  wire logic        clock,
  input  wire logic        reset,
  seg7_scan_ctrl_if.slave  host
);
  localparam int CW = $clog2(DIV);
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] c_cnt_last = CW'(DIV - 1);
  localparam logic [CW-1:0] c_blank    = CW'(BLANK);
  localparam logic [IW-1:0] c_idx_last = IW'(NDIG - 1);

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [4*NDIG-1:0] r_sh_data;
  logic [NDIG-1:0]   r_sh_dp;
  logic [NDIG-1:0]   r_sh_den;
  logic [4*NDIG-1:0] r_d_data;
  logic [NDIG-1:0]   r_d_dp;
  logic [NDIG-1:0]   r_d_den;
  logic              r_pending;
  logic [NDIG-1:0]   r_an;
  logic [7:0]        r_seg;
  logic              r_frame_tick;

  logic              w_wrap;
  logic              w_boundary;
  logic              w_apply;
  logic [CW-1:0]     w_cnt_nx;
  logic [IW-1:0]     w_idx_nx;
  logic [4*NDIG-1:0] w_d_data_nx;
  logic [NDIG-1:0]   w_d_dp_nx;
  logic [NDIG-1:0]   w_d_den_nx;
  logic [NDIG-1:0]   w_nib_zero;
  logic [NDIG-1:0]   w_zero_above;
  logic [3:0]        w_nibble;
  logic [7:0]        w_pattern;
  logic              w_blank;

  // Next-state counters and display set; the outputs are registered from
  // these so that they change on the same edge as the counters.
  always_comb begin
    w_wrap      = (r_cnt == c_cnt_last);
    w_boundary  = w_wrap && (r_idx == c_idx_last);
    w_apply     = w_boundary && r_pending;
    w_cnt_nx    = w_wrap ? '0 : r_cnt + 1'b1;
    w_idx_nx    = r_idx;
    if (w_wrap) begin
      w_idx_nx = (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
    end
    w_d_data_nx = w_apply ? r_sh_data : r_d_data;
    w_d_dp_nx   = w_apply ? r_sh_dp   : r_d_dp;
    w_d_den_nx  = w_apply ? r_sh_den  : r_d_den;
  end

  // w_zero_above[k]: digit k and every digit to its left hold nibble 0.
  for (genvar k = 0; k < NDIG; k++) begin : g_lz
    assign w_nib_zero[k] = (w_d_data_nx[4*k +: 4] == 4'h0);
    if (k == NDIG - 1) begin : g_top
      assign w_zero_above[k] = w_nib_zero[k];
    end else begin : g_mid
      assign w_zero_above[k] = w_nib_zero[k] && w_zero_above[k+1];
    end
  end

  assign w_nibble = w_d_data_nx[{w_idx_nx, 2'b00} +: 4];

  decode_7seg u_decode (
    .nibble  (w_nibble),
    .pattern (w_pattern)
  );

  // A slot is dark during its guard clocks, when disabled, or when it is a
  // suppressed leading zero (digit 0 always stays visible).
  always_comb begin
    w_blank = (w_cnt_nx < c_blank) || !w_d_den_nx[w_idx_nx];
    if ((LZS != 0) && (w_idx_nx != '0) && w_zero_above[w_idx_nx]) begin
      w_blank = 1'b1;
    end
  end

  // Prescaler and digit index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_idx <= w_idx_nx;
    end
  end

  // Shadow capture. A load on a boundary edge still leaves pending set,
  // because the boundary consumed the previous shadow contents.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sh_data <= '0;
      r_sh_dp   <= '0;
      r_sh_den  <= '0;
      r_pending <= 1'b0;
    end else begin
      if (host.load) begin
        r_sh_data <= host.data;
        r_sh_dp   <= host.dp;
        r_sh_den  <= host.den;
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  // Display set, updated only at frame boundaries.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_d_data <= '0;
      r_d_dp   <= '0;
      r_d_den  <= '0;
    end else begin
      r_d_data <= w_d_data_nx;
      r_d_dp   <= w_d_dp_nx;
      r_d_den  <= w_d_den_nx;
    end
  end

  // Registered LED pins and frame pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an         <= '0;
      r_seg        <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_boundary;
      if (w_blank) begin
        r_an  <= '0;
        r_seg <= '0;
      end else begin
        r_an  <= NDIG'(1) << w_idx_nx;
        r_seg <= {w_pattern[7:1], w_d_dp_nx[w_idx_nx]};
      end
    end
  end

  assign host.busy       = r_pending;
  assign host.frame_tick = r_frame_tick;
  assign host.an         = r_an;
  assign host.seg        = r_seg;
endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_ctrl
//  Description : Self-checking bench for seg7_scan_ctrl (NDIG=4, DIV=8,
//                BLANK=2). It runs two instances, one with LZS=0 and one with
//                LZS=1, from the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  den = '0;
  bit          sel = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NDIG(4)) if0 ();
  seg7_scan_ctrl_if #(.NDIG(4)) if1 ();

  assign if0.load = load;
  assign if0.data = data;
  assign if0.dp   = dp;
  assign if0.den  = den;
  assign if1.load = load;
  assign if1.data = data;
  assign if1.dp   = dp;
  assign if1.den  = den;

  seg7_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK(2), .LZS(0)) dut0 (
    .clock (clk),
    .reset (rst),
    .host  (if0)
  );
  seg7_scan_ctrl #(.NDIG(4), .DIV(8), .BLANK(2), .LZS(1)) dut1 (
    .clock (clk),
    .reset (rst),
    .host  (if1)
  );

  logic [3:0] m_an;
  logic [7:0] m_seg;
  logic       m_busy;
  logic       m_tick;
  assign m_an   = sel ? if1.an : if0.an;
  assign m_seg  = sel ? if1.seg : if0.seg;
  assign m_busy = sel ? if1.busy : if0.busy;
  assign m_tick = sel ? if1.frame_tick : if0.frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit          sel;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  den;
    logic [31:0] segs;   // {d3,d2,d1,d0} expected lit patterns
    logic [3:0]  mask;   // digits expected lit
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one full frame of expected per-clock {an,seg} values.
  task automatic push_frame(input logic [31:0] segs, input logic [3:0] mask);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 8; c++) begin
        exp_t e;
        if (c < 2 || !mask[d]) begin
          e.an  = 4'b0000;
          e.seg = 8'h00;
        end else begin
          e.an  = 4'b0001 << d;
          e.seg = segs[8*d +: 8];
        end
        sb.push_back(e);
      end
    end
  endtask

  // Return at the first following negedge that sees frame_tick high.
  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (m_tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: got no frame_tick expected one within 80 clocks");
    end
  endtask

  // Compare 32 consecutive clocks against the scoreboard, starting now.
  task automatic check_frame(input string name);
    for (int i = 0; i < 32; i++) begin
      if (i > 0) @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s: got output with empty scoreboard expected an entry", name);
      end else begin
        exp_t e = sb.pop_front();
        check(name, {20'h0, m_an, m_seg}, {20'h0, e.an, e.seg});
      end
    end
  endtask

  task automatic drive_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
    load = 1'b1;
    data = d;
    dp   = p;
    den  = e;
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h1A3F, 4'b0010, 4'hF,    32'h60EEF38E, 4'b1111};
    vecs[1] = '{1'b0, 16'h5C0B, 4'b1000, 4'b1011, 32'hB79CFC3E, 4'b1011};
    vecs[2] = '{1'b1, 16'h0070, 4'b0000, 4'hF,    32'h0000E0FC, 4'b0011};
    vecs[3] = '{1'b1, 16'h0000, 4'b0100, 4'hF,    32'h000000FC, 4'b0001};
    vecs[4] = '{1'b1, 16'h0102, 4'b0000, 4'hF,    32'h0060FCDA, 4'b0111};
    vecs[5] = '{1'b0, 16'h0000, 4'b0000, 4'hF,    32'hFCFCFCFC, 4'b1111};

    // Reset state
    @(negedge clk);
    check("rst_an",   {28'h0, if0.an},  32'h0);
    check("rst_seg",  {24'h0, if0.seg}, 32'h0);
    check("rst_busy", {31'h0, if0.busy}, 32'h0);
    check("rst_tick", {31'h0, if0.frame_tick}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset: dark display, frame_tick every 32 clocks
    for (int n = 1; n <= 64; n++) begin
      @(negedge clk);
      check("idle_dark", {20'h0, if0.an, if0.seg}, 32'h0);
      check("idle_tick", {31'h0, if0.frame_tick}, (n == 32 || n == 64) ? 32'h1 : 32'h0);
    end

    // Table-driven single loads
    for (int v = 0; v < 6; v++) begin
      sel = vecs[v].sel;
      wait_tick();
      drive_load(vecs[v].data, vecs[v].dp, vecs[v].den);
      push_frame(vecs[v].segs, vecs[v].mask);
      @(negedge clk);
      load = 1'b0;
      check("vec_busy_set", {31'h0, m_busy}, 32'h1);
      wait_tick();
      check("vec_busy_clr", {31'h0, m_busy}, 32'h0);
      check_frame("vec_frame");
    end

    // Two loads within one frame: only the last one shows
    sel = 1'b0;
    wait_tick();
    drive_load(16'h1111, 4'h0, 4'hF);
    @(negedge clk);
    drive_load(16'h2222, 4'h0, 4'hF);
    push_frame(32'hDADADADA, 4'hF);
    @(negedge clk);
    load = 1'b0;
    wait_tick();
    check("dbl_busy_clr", {31'h0, m_busy}, 32'h0);
    check_frame("dbl_frame");

    // Load exactly on the boundary edge while 0005 is pending
    wait_tick();
    drive_load(16'h0005, 4'h0, 4'hF);
    push_frame(32'hFCFCFCB6, 4'hF);
    @(negedge clk);
    load = 1'b0;
    repeat (30) @(negedge clk);
    drive_load(16'hABCD, 4'h0, 4'hF);
    push_frame(32'hEE3E9C7A, 4'hF);
    @(negedge clk);
    load = 1'b0;
    check("bnd_tick", {31'h0, m_tick}, 32'h1);
    check("bnd_busy", {31'h0, m_busy}, 32'h1);
    check_frame("bnd_old_frame");
    check("bnd_busy_hold", {31'h0, m_busy}, 32'h1);
    wait_tick();
    check("bnd_busy_clr", {31'h0, m_busy}, 32'h0);
    check_frame("bnd_new_frame");

    // Asynchronous reset at cnt=5 of digit 2 with a load pending
    wait_tick();
    drive_load(16'h9999, 4'h0, 4'hF);
    @(negedge clk);
    load = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_out", {20'h0, m_an, m_seg}, {20'h0, 4'b0100, 8'h3E});
    check("pre_rst_busy", {31'h0, m_busy}, 32'h1);
    rst = 1'b1;
    #1;
    check("arst_out", {20'h0, m_an, m_seg}, 32'h0);
    check("arst_busy", {31'h0, m_busy}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(32'h0, 4'h0);
    wait_tick();
    check("post_rst_busy", {31'h0, m_busy}, 32'h0);
    check_frame("post_rst_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
